// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter/mux.
// Holds the arbiter FSM state encoding and the round-robin search used by
// axis_rr_arbiter so that other multi-master blocks can share the same policy.
package axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Widest request vector the round-robin search supports.
    localparam int RR_MAX_REQ = 64;

    // Index of the first set request at or after 'start', wrapping at 'n'.
    // Returns -1 when no request is set.
    function automatic int rr_next_index(input logic [RR_MAX_REQ-1:0] req,
                                         input int                    n,
                                         input int                    start);
        int idx;
        int pick;
        pick = -1;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            if (k < n) begin
                idx = start + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (pick < 0 && req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin arbiter.
// start_idx is the round-robin pointer: the requester searched first, i.e. one
// past the last granted index. Produces a one-hot grant plus its binary index.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start_idx,
    output logic               gnt_vld,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    int pick;

    // Search the request vector from the pointer upward with wrap.
    always_comb begin
        pick       = rr_next_index(RR_MAX_REQ'(req), NUM_REQ, int'(start_idx));
        gnt_vld    = (pick >= 0);
        gnt_idx    = '0;
        gnt_onehot = '0;
        if (pick >= 0) begin
            gnt_idx    = IDX_W'(pick);
            gnt_onehot = NUM_REQ'(1) << pick;
        end
    end

endmodule

// File: rtl/axis_arbiter_mux.sv
// axis_arbiter_mux: merges NUM_STREAMS AXI-stream inputs onto one registered
// AXI-stream output with packet-granular round-robin arbitration.
// Optional feature macro: AXIS_ARBITER_MUX_TID_EN adds axis_o_tid, the source
// stream index of the beat currently held in the output register.
module axis_arbiter_mux
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES  = 1,
    parameter int NUM_STREAMS = 2
) (
    input  logic                                clk,
    input  logic                                sreset,
    output logic [NUM_STREAMS-1:0]              axis_i_tready,
    input  logic [NUM_STREAMS-1:0]              axis_i_tvalid,
    input  logic [NUM_STREAMS-1:0]              axis_i_tlast,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                                axis_o_tready,
    output logic                                axis_o_tvalid,
    output logic                                axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]             axis_o_tdata
`ifdef AXIS_ARBITER_MUX_TID_EN
    ,
    output logic [$clog2(NUM_STREAMS)-1:0]      axis_o_tid
`endif
);

    localparam int DW    = AXIS_BYTES * 8;
    localparam int IDX_W = $clog2(NUM_STREAMS);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant;
    logic [NUM_STREAMS-1:0] grant_oh;
    logic [IDX_W-1:0]       rr_ptr;

    logic                   arb_vld;
    logic [NUM_STREAMS-1:0] arb_onehot;
    logic [IDX_W-1:0]       arb_idx;

    logic                   out_ready;
    logic                   in_hs;
    logic [DW-1:0]          sel_data;
    logic                   sel_last;

    axis_rr_arbiter #(
        .NUM_REQ (NUM_STREAMS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (axis_i_tvalid),
        .start_idx  (rr_ptr),
        .gnt_vld    (arb_vld),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_ready = !axis_o_tvalid || axis_o_tready;
    assign sel_data  = axis_i_tdata[int'(grant)*DW +: DW];
    assign sel_last  = axis_i_tlast[grant];
    assign in_hs     = (state == LOCKED) && axis_i_tvalid[grant] && out_ready;

    // Only the granted input ever sees tready, and only while locked.
    always_comb begin
        axis_i_tready = '0;
        if (state == LOCKED && out_ready) begin
            axis_i_tready = grant_oh;
        end
    end

    // Arbitration FSM: pick a packet owner in IDLE, hold it until tlast is taken.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_oh <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_onehot;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_hs && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == IDX_W'(NUM_STREAMS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: a load replaces the held beat, otherwise a sink accept empties it.
    always_ff @(posedge clk) begin
        if (sreset) begin
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tdata  <= '0;
`ifdef AXIS_ARBITER_MUX_TID_EN
            axis_o_tid    <= '0;
`endif
        end else if (in_hs) begin
            axis_o_tvalid <= 1'b1;
            axis_o_tlast  <= sel_last;
            axis_o_tdata  <= sel_data;
`ifdef AXIS_ARBITER_MUX_TID_EN
            axis_o_tid    <= grant;
`endif
        end else if (axis_o_tready) begin
            axis_o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_arbiter_mux.sv
// Directed testbench for axis_arbiter_mux. With AXIS_ARBITER_MUX_TID_EN the
// DUT is built with four streams and the source-index port is exercised.
`timescale 1ns/1ps
module tb_axis_arbiter_mux;

`ifdef AXIS_ARBITER_MUX_TID_EN
    localparam int NS = 4;
`else
    localparam int NS = 2;
`endif
    localparam int DW   = 8;
    localparam int TW   = $clog2(NS);
    localparam int MAXB = 16;
    localparam int MAXC = 64;

    logic            clk = 1'b0;
    logic            sreset;
    logic [NS-1:0]   i_tready;
    logic [NS-1:0]   i_tvalid;
    logic [NS-1:0]   i_tlast;
    logic [NS*DW-1:0] i_tdata;
    logic            o_tready;
    logic            o_tvalid;
    logic            o_tlast;
    logic [DW-1:0]   o_tdata;
    logic [TW-1:0]   o_tid;

    int vectors     = 0;
    int miscompares = 0;

    // Per-stream source beats: data, last flag, idle cycles before the beat.
    logic [7:0] src_data [NS][MAXB];
    logic       src_last [NS][MAXB];
    int         src_gap  [NS][MAXB];
    int         src_len  [NS];
    int         src_pos  [NS];
    int         gap_cnt  [NS];
    int         hs_first [NS];
    int         hs_last  [NS];
    logic       tready_seen [NS];
    int         tready_viol;

    // Captured output beats.
    logic [7:0]    cap_data [MAXC];
    logic          cap_last [MAXC];
    logic [TW-1:0] cap_tid  [MAXC];
    int            cap_cyc  [MAXC];
    int            cap_n;

    // Per-cycle output ready pattern; cycles past its length see ready=1.
    logic rdy_pat [MAXC];
    int   rdy_len;

    axis_arbiter_mux #(
        .AXIS_BYTES  (1),
        .NUM_STREAMS (NS)
    ) dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (i_tready),
        .axis_i_tvalid (i_tvalid),
        .axis_i_tlast  (i_tlast),
        .axis_i_tdata  (i_tdata),
        .axis_o_tready (o_tready),
        .axis_o_tvalid (o_tvalid),
        .axis_o_tlast  (o_tlast),
        .axis_o_tdata  (o_tdata)
`ifdef AXIS_ARBITER_MUX_TID_EN
        ,
        .axis_o_tid    (o_tid)
`endif
    );

`ifndef AXIS_ARBITER_MUX_TID_EN
    assign o_tid = '0;
`endif

    always #5 clk = ~clk;

    task automatic clear_bench();
        for (int s = 0; s < NS; s++) begin
            src_len[s]     = 0;
            src_pos[s]     = 0;
            gap_cnt[s]     = 0;
            hs_first[s]    = -1;
            hs_last[s]     = -1;
            tready_seen[s] = 1'b0;
        end
        tready_viol = 0;
        cap_n       = 0;
        rdy_len     = 0;
    endtask

    task automatic add_beat(input int s, input logic [7:0] d, input logic l, input int gap);
        src_data[s][src_len[s]] = d;
        src_last[s][src_len[s]] = l;
        src_gap[s][src_len[s]]  = gap;
        if (src_len[s] == 0) gap_cnt[s] = gap;
        src_len[s] = src_len[s] + 1;
    endtask

    task automatic do_reset();
        sreset   = 1'b1;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        o_tready = 1'b1;
        @(posedge clk); #1;
        sreset = 1'b0;
        clear_bench();
    endtask

    // Runs n cycles of the source/sink models; sreset is pulsed in cycle rst_cyc.
    task automatic run_cycles(input int n, input int rst_cyc);
        logic          hs [NS];
        logic          stall_prev;
        logic [DW-1:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        for (int c = 0; c < n; c++) begin
            sreset   = (c == rst_cyc);
            o_tready = (c < rdy_len) ? rdy_pat[c] : 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (src_pos[s] < src_len[s] && gap_cnt[s] == 0) begin
                    i_tvalid[s]            = 1'b1;
                    i_tlast[s]             = src_last[s][src_pos[s]];
                    i_tdata[s*DW +: DW]    = src_data[s][src_pos[s]];
                end else begin
                    i_tvalid[s]            = 1'b0;
                    i_tlast[s]             = 1'b0;
                    i_tdata[s*DW +: DW]    = '0;
                end
            end
            #1;
            if (o_tvalid && o_tready && cap_n < MAXC) begin
                cap_data[cap_n] = o_tdata;
                cap_last[cap_n] = o_tlast;
                cap_tid[cap_n]  = o_tid;
                cap_cyc[cap_n]  = c;
                cap_n = cap_n + 1;
            end
            if (stall_prev && o_tvalid) begin
                vectors++;
                if (o_tdata !== stall_data) begin
                    miscompares++;
                    $display("FAIL stall_hold cycle %0d: tdata %h, required %h", c, o_tdata, stall_data);
                end
            end
            stall_prev = o_tvalid && !o_tready;
            stall_data = o_tdata;
            if ($countones(i_tready) > 1) tready_viol++;
            for (int s = 0; s < NS; s++) begin
                if (i_tready[s]) tready_seen[s] = 1'b1;
                hs[s] = i_tvalid[s] && i_tready[s];
                if (hs[s]) begin
                    if (hs_first[s] < 0) hs_first[s] = c;
                    hs_last[s] = c;
                end
            end
            @(posedge clk); #1;
            for (int s = 0; s < NS; s++) begin
                if (hs[s]) begin
                    src_pos[s] = src_pos[s] + 1;
                    gap_cnt[s] = (src_pos[s] < src_len[s]) ? src_gap[s][src_pos[s]] : 0;
                end else if (gap_cnt[s] > 0) begin
                    gap_cnt[s] = gap_cnt[s] - 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        sreset   = 1'b1;
        i_tvalid = '1;
        i_tlast  = '1;
        i_tdata  = '1;
        o_tready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b, required 0", o_tvalid); end
        vectors++;
        if (o_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b, required 0", o_tlast); end
        vectors++;
        if (o_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata: got %h, required 00", o_tdata); end
        vectors++;
        if (i_tready !== '0) begin miscompares++; $display("FAIL reset_tready: got %b, required 0", i_tready); end
        vectors++;
        if (o_tid !== '0) begin miscompares++; $display("FAIL reset_tid: got %0d, required 0", o_tid); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        logic       exp_l [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_l = '{1'b0, 1'b0, 1'b1};
        do_reset();
        add_beat(0, 8'h11, 1'b0, 0);
        add_beat(0, 8'h22, 1'b0, 0);
        add_beat(0, 8'h33, 1'b1, 0);
        run_cycles(8, -1);
        vectors++;
        if (cap_n !== 3) begin miscompares++; $display("FAIL single_count: got %0d beats, required 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL single_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (cap_cyc[0] !== 2) begin miscompares++; $display("FAIL single_latency: first beat at cycle %0d, required 2", cap_cyc[0]); end
        vectors++;
        if (tready_seen[1] !== 1'b0) begin miscompares++; $display("FAIL single_idle_tready: got %b, required 0", tready_seen[1]); end
        vectors++;
        if (tready_viol !== 0) begin miscompares++; $display("FAIL single_onehot_tready: %0d cycles, required 0", tready_viol); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [12];
        exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            add_beat(0, 8'hA0, 1'b0, 0);
            add_beat(0, 8'hA1, 1'b1, 0);
            add_beat(1, 8'hB0, 1'b0, 0);
            add_beat(1, 8'hB1, 1'b1, 0);
        end
        run_cycles(26, -1);
        vectors++;
        if (cap_n !== 12) begin miscompares++; $display("FAIL rr_count: got %0d beats, required 12", cap_n); end
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL rr_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i], exp_d[i], (i % 2 == 1));
            end
        end
        vectors++;
        if (tready_viol !== 0) begin miscompares++; $display("FAIL rr_onehot_tready: %0d cycles, required 0", tready_viol); end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_d [3];
        logic       exp_l [3];
        exp_d = '{8'h10, 8'h20, 8'h50};
        exp_l = '{1'b0, 1'b1, 1'b1};
        do_reset();
        add_beat(1, 8'h10, 1'b0, 0);
        add_beat(1, 8'h20, 1'b1, 3);
        add_beat(0, 8'h50, 1'b1, 1);
        run_cycles(14, -1);
        vectors++;
        if (cap_n !== 3) begin miscompares++; $display("FAIL lock_count: got %0d beats, required 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL lock_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (hs_first[0] !== 7 || hs_last[1] !== 5) begin
            miscompares++;
            $display("FAIL lock_order: s0 first accept %0d, s1 last accept %0d, required 7 and 5", hs_first[0], hs_last[1]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) add_beat(0, 8'(i + 1), (i == 3), 0);
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b1;
        rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;
        rdy_len = 6;
        run_cycles(12, -1);
        vectors++;
        if (cap_n !== 4) begin miscompares++; $display("FAIL bp_count: got %0d beats, required 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap_data[i] !== 8'(i + 1) || cap_last[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got %h/%b, required %h/%b", i, cap_data[i], cap_last[i], 8'(i + 1), (i == 3));
            end
        end
        vectors++;
        if (cap_cyc[1] !== 5) begin miscompares++; $display("FAIL bp_stall_cycle: beat 2 taken at %0d, required 5", cap_cyc[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) add_beat(0, 8'(i + 1), (i == 3), 0);
        run_cycles(4, 3);
        sreset = 1'b0;
        vectors++;
        if (cap_n !== 2 || cap_data[0] !== 8'h01 || cap_data[1] !== 8'h02) begin
            miscompares++;
            $display("FAIL rstmid_pre: got %0d beats (%h,%h), required 2 (01,02)", cap_n, cap_data[0], cap_data[1]);
        end
        clear_bench();
        i_tvalid = '0;
        #1;
        vectors++;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tvalid: got %b, required 0", o_tvalid); end
        vectors++;
        if (i_tready !== '0) begin miscompares++; $display("FAIL rstmid_tready: got %b, required 0", i_tready); end
        add_beat(0, 8'hC0, 1'b1, 0);
        add_beat(1, 8'hD0, 1'b1, 0);
        run_cycles(10, -1);
        vectors++;
        if (cap_n !== 2 || cap_data[0] !== 8'hC0 || cap_data[1] !== 8'hD0) begin
            miscompares++;
            $display("FAIL rstmid_rr_restart: got %0d beats (%h,%h), required 2 (c0,d0)", cap_n, cap_data[0], cap_data[1]);
        end
    endtask

`ifdef AXIS_ARBITER_MUX_TID_EN
    task automatic test_tid();
        logic [7:0]    exp_d [4];
        logic [TW-1:0] exp_t [4];
        exp_d = '{8'h2A, 8'h2B, 8'h3A, 8'h3B};
        exp_t = '{TW'(2), TW'(2), TW'(3), TW'(3)};
        do_reset();
        add_beat(2, 8'h2A, 1'b0, 0);
        add_beat(2, 8'h2B, 1'b1, 0);
        add_beat(3, 8'h3A, 1'b0, 0);
        add_beat(3, 8'h3B, 1'b1, 0);
        run_cycles(14, -1);
        vectors++;
        if (cap_n !== 4) begin miscompares++; $display("FAIL tid_count: got %0d beats, required 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap_data[i] !== exp_d[i] || cap_tid[i] !== exp_t[i]) begin
                miscompares++;
                $display("FAIL tid_beat%0d: got %h tid %0d, required %h tid %0d", i, cap_data[i], cap_tid[i], exp_d[i], exp_t[i]);
            end
        end
    endtask
`endif

    initial begin
        sreset   = 1'b1;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        o_tready = 1'b1;
        clear_bench();
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid();
`ifdef AXIS_ARBITER_MUX_TID_EN
        test_tid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
